// File: rtl/sr_flag_pkg.sv
// Shared types and constants for the SR flag arbiter: op and FSM encodings, error-counter width.
package sr_flag_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_CLR  = 2'b01,
        OP_SET  = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam int unsigned ERRCNT_W = 8;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Request/grant bus of the SR flag arbiter. err_cnt exists only with SR_FLAG_ARB_ERRCNT_EN.
interface sr_flag_arbiter_if
    import sr_flag_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NFLAG = 8
);
    localparam int unsigned IW = $clog2(NFLAG);

    logic                  clr_all;
    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [IW*NREQ-1:0]    req_idx;
    logic [NREQ-1:0]       grant;
    logic [NFLAG-1:0]      flags;
    logic                  err;
    logic                  busy;
`ifdef SR_FLAG_ARB_ERRCNT_EN
    logic [ERRCNT_W-1:0]   err_cnt;

    modport master (
        output clr_all, req_valid, req_op, req_idx,
        input  grant, flags, err, busy, err_cnt
    );
    modport slave (
        input  clr_all, req_valid, req_op, req_idx,
        output grant, flags, err, busy, err_cnt
    );
`else
    modport master (
        output clr_all, req_valid, req_op, req_idx,
        input  grant, flags, err, busy
    );
    modport slave (
        input  clr_all, req_valid, req_op, req_idx,
        output grant, flags, err, busy
    );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr_i, wrapping around.
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] winner_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin : p_sel
        int unsigned j;
        j        = 0;
        winner_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            j = int'(ptr_i) + off;
            if (j >= NREQ) j = j - NREQ;
            if (!any_o && valid_i[j[PW-1:0]]) begin
                any_o              = 1'b1;
                winner_o[j[PW-1:0]] = 1'b1;
                idx_o              = j[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated set/reset flag bank with a two-state IDLE/GRANT handshake.
// Optional saturating illegal-op counter enabled by SR_FLAG_ARB_ERRCNT_EN.
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NFLAG = 8
) (
    input logic                clk,
    input logic                rst,
    sr_flag_arbiter_if.slave   bus
);

    localparam int unsigned IW = $clog2(NFLAG);
    localparam int unsigned PW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NFLAG-1:0]  flags_q, flags_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              err_q, err_d;
    logic              rdy_q;

    logic [NREQ-1:0]   win_oh;
    logic [PW-1:0]     win_idx;
    logic              win_any;
    op_e               win_op;
    logic [IW-1:0]     win_tgt;
    logic              start;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .valid_i  (bus.req_valid),
        .ptr_i    (ptr_q),
        .winner_o (win_oh),
        .idx_o    (win_idx),
        .any_o    (win_any)
    );

    always_comb begin
        win_op  = op_e'(bus.req_op[2*int'(win_idx) +: 2]);
        win_tgt = bus.req_idx[IW*int'(win_idx) +: IW];
    end

    // rdy_q holds off arbitration for the first edge after reset release.
    assign start = (state_q == ST_IDLE) && rdy_q && !bus.clr_all && win_any;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = start ? ST_GRANT : ST_IDLE;
            ST_GRANT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        grant_d = '0;
        err_d   = 1'b0;
        ptr_d   = ptr_q;
        if (start) begin
            grant_d = win_oh;
            ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            case (win_op)
                OP_CLR:  flags_d[win_tgt] = 1'b0;
                OP_SET:  flags_d[win_tgt] = 1'b1;
                OP_ILL:  err_d = 1'b1;
                default: ;
            endcase
        end
        // Clear wins over any op landing on the same edge.
        if (bus.clr_all) flags_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            flags_q <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            flags_q <= flags_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    assign bus.grant = grant_q;
    assign bus.flags = flags_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state_q == ST_GRANT);

`ifdef SR_FLAG_ARB_ERRCNT_EN
    logic [ERRCNT_W-1:0] errcnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       errcnt_q <= '0;
        else if (err_d) errcnt_q <= sat_inc(errcnt_q);
    end

    assign bus.err_cnt = errcnt_q;
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter: a transaction-level model predicts grant order and flag state.
module tb_sr_flag_arbiter;
    import sr_flag_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned NFLAG = 8;
    localparam int unsigned IW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_flag_arbiter_if #(.NREQ(NREQ), .NFLAG(NFLAG)) bus ();

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NREQ-1:0]  grant;
        logic [NFLAG-1:0] flags;
        logic             err;
        int               errcnt;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               n_cmp = 0;
    int               n_fail = 0;
    bit               mon_en = 1'b0;
    logic [NFLAG-1:0] flags_m = '0;
    int               ptr_m = 0;
    int               errcnt_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.grant !== '0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got %b, required none", bus.grant);
                end else begin
                    mon_e = sb.pop_front();
                    check("grant", 32'(bus.grant), 32'(mon_e.grant));
                    check("flags", 32'(bus.flags), 32'(mon_e.flags));
                    check("err", 32'(bus.err), 32'(mon_e.err));
                    check("busy", 32'(bus.busy), 32'd1);
`ifdef SR_FLAG_ARB_ERRCNT_EN
                    check("err_cnt", 32'(bus.err_cnt), 32'(mon_e.errcnt));
`endif
                end
            end else begin
                check("idle_err", 32'(bus.err), 32'd0);
                check("idle_busy", 32'(bus.busy), 32'd0);
            end
        end
    end

    // Reference model: one accepted command, applied in round-robin order.
    task automatic push_op(input int k, input logic [1:0] op, input int idx);
        exp_t e;
        if (op == 2'b01)      flags_m[idx] = 1'b0;
        else if (op == 2'b10) flags_m[idx] = 1'b1;
        else if (op == 2'b11) errcnt_m = (errcnt_m < 255) ? errcnt_m + 1 : 255;
        e.grant    = '0;
        e.grant[k] = 1'b1;
        e.flags    = flags_m;
        e.err      = (op == 2'b11);
        e.errcnt   = errcnt_m;
        sb.push_back(e);
        ptr_m = (k + 1) % NREQ;
    endtask

    task automatic issue_batch(input logic [NREQ-1:0] m, input logic [2*NREQ-1:0] o,
                               input logic [IW*NREQ-1:0] x);
        int p0;
        int k;
        p0 = ptr_m;
        for (int off = 0; off < NREQ; off++) begin
            k = (p0 + off) % NREQ;
            if (m[k]) push_op(k, o[2*k +: 2], int'(x[IW*k +: IW]));
        end
        bus.req_op    = o;
        bus.req_idx   = x;
        bus.req_valid = m;
    endtask

    task automatic wait_batch(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            bus.req_valid = bus.req_valid & ~bus.grant;
            if (bus.req_valid == '0) done = 1'b1;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        if (!done) bus.req_valid = '0;
        repeat (2) @(negedge clk);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        bus.clr_all = 1'b1;
        @(negedge clk);
        bus.clr_all = 1'b0;
        flags_m = '0;
        check("clr_flags", 32'(bus.flags), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0]    m;
        logic [2*NREQ-1:0]  o;
        logic [IW*NREQ-1:0] x;
        bit                 seen;

        bus.clr_all   = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_idx   = '0;
        #2 rst = 1'b0;
        #1;
        check("reset_grant", 32'(bus.grant), 32'd0);
        check("reset_flags", 32'(bus.flags), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // All four requesters set flags 0..3; grants must come out 0,1,2,3.
        issue_batch(4'hF, {4{2'b10}}, {3'd3, 3'd2, 3'd1, 3'd0});
        wait_batch("rr");
        check("rr_flags", 32'(bus.flags), 32'h0F);

        issue_batch(4'b0100, 8'b00_10_00_00, {3'd0, 3'd5, 3'd0, 3'd0});
        wait_batch("set5");
        issue_batch(4'b0100, 8'b00_01_00_00, {3'd0, 3'd5, 3'd0, 3'd0});
        wait_batch("clr5");
        check("clr5_flags", 32'(bus.flags), 32'h0F);

        // Illegal op against flags=08.
        clr_pulse();
        issue_batch(4'b0001, 8'b00_00_00_10, {3'd0, 3'd0, 3'd0, 3'd3});
        wait_batch("set3");
        issue_batch(4'b0010, 8'b00_00_11_00, {3'd0, 3'd0, 3'd3, 3'd0});
        wait_batch("ill");
        check("ill_flags", 32'(bus.flags), 32'h08);

`ifdef SR_FLAG_ARB_ERRCNT_EN
        for (int i = 0; i < 256; i++) begin
            issue_batch(4'b0010, 8'b00_00_11_00, {3'd0, 3'd0, 3'd3, 3'd0});
            wait_batch("ill_sat");
        end
        check("err_cnt_sat", 32'(bus.err_cnt), 32'd255);
`endif

        // Fill all flags, then collide clr_all with a fresh request.
        issue_batch(4'hF, {4{2'b10}}, {3'd4, 3'd2, 3'd1, 3'd0});
        wait_batch("fill_a");
        issue_batch(4'hF, {4{2'b10}}, {3'd7, 3'd6, 3'd5, 3'd3});
        wait_batch("fill_b");
        check("fill_flags", 32'(bus.flags), 32'hFF);
        bus.clr_all      = 1'b1;
        bus.req_valid    = 4'b0001;
        bus.req_op[1:0]  = 2'b10;
        bus.req_idx[2:0] = 3'd1;
        @(negedge clk);
        check("collide_flags", 32'(bus.flags), 32'd0);
        check("collide_grant", 32'(bus.grant), 32'd0);
        bus.clr_all = 1'b0;
        flags_m     = '0;
        push_op(0, 2'b10, 1);
        wait_batch("collide_retry");
        check("collide_retry_flags", 32'(bus.flags), 32'h02);

        // Withdrawn request: requester 3 pulses valid only across the GRANT->IDLE edge.
        clr_pulse();
        issue_batch(4'b0001, 8'b00_00_00_10, {3'd0, 3'd0, 3'd0, 3'd6});
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.grant[0]) seen = 1'b1;
        end
        check("withdraw_req0_granted", 32'(seen), 32'd1);
        bus.req_op[7:6]   = 2'b10;
        bus.req_idx[11:9] = 3'd7;
        bus.req_valid     = 4'b1000;
        @(negedge clk);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
        check("withdraw_sb_empty", 32'(sb.size()), 32'd0);
        check("withdraw_flags", 32'(bus.flags), 32'(flags_m));

        // Asynchronous reset mid-GRANT with flags=A5.
        clr_pulse();
        issue_batch(4'hF, {4{2'b10}}, {3'd7, 3'd5, 3'd2, 3'd0});
        wait_batch("a5");
        check("a5_flags", 32'(bus.flags), 32'hA5);
        issue_batch(4'b0001, 8'b00_00_00_10, {3'd0, 3'd0, 3'd0, 3'd0});
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.grant[0]) seen = 1'b1;
        end
        check("rst_pre_grant", 32'(seen), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_flags", 32'(bus.flags), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
`ifdef SR_FLAG_ARB_ERRCNT_EN
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
        bus.req_valid = '0;
        flags_m  = '0;
        ptr_m    = 0;
        errcnt_m = 0;
        sb.delete();
        issue_batch(4'b0010, 8'b00_00_10_00, {3'd0, 3'd0, 3'd4, 3'd0});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("first_edge_no_grant", 32'(bus.grant), 32'd0);
        wait_batch("post_reset");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) clr_pulse();
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            o = (2*NREQ)'($urandom);
            x = (IW*NREQ)'($urandom);
            issue_batch(m, o, x);
            wait_batch("rand");
        end
        check("final_flags", 32'(bus.flags), 32'(flags_m));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
